rf_wb_arbiter: RTL and testbench

//  Write-side master for the register file's single write port (we3/a3/wd3).

---
 rtl/rf_wb_arbiter_pkg.sv | 9 +
 rtl/rf_wb_arbiter_if.sv | 27 ++
 rtl/rf_wb_arbiter_wb_fifo.sv | 50 +++++
 rtl/rf_wb_arbiter.sv | 69 ++++++
 tb/tb_rf_wb_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared widths and the buffered writeback request type
package rf_wb_arbiter_pkg;
    localparam int ADDRESS_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback request channels, hazard query and register-file write port
//   master: requesters / register file / hazard logic side
//   slave : the arbiter itself
interface rf_wb_arbiter_if #(parameter int FIFO_DEPTH = 4);
    import rf_wb_arbiter_pkg::*;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic                     p_valid, p_ready;
    logic [ADDRESS_WIDTH-1:0] p_addr;
    logic [DATA_WIDTH-1:0]    p_data;
    logic                     s_valid, s_ready;
    logic [ADDRESS_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0]    s_data;
    logic [ADDRESS_WIDTH-1:0] q_addr;
    logic                     q_pending;
    logic [CW-1:0]            fifo_count;
    logic                     we3;
    logic [ADDRESS_WIDTH-1:0] a3;
    logic [DATA_WIDTH-1:0]    wd3;
    modport master (
        output p_valid, p_addr, p_data, s_valid, s_addr, s_data, q_addr,
        input  p_ready, s_ready, q_pending, fifo_count, we3, a3, wd3
    );
    modport slave (
        input  p_valid, p_addr, p_data, s_valid, s_addr, s_data, q_addr,
        output p_ready, s_ready, q_pending, fifo_count, we3, a3, wd3
    );
endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests with per-entry valid/addr taps
//   clk, rst (async active-low); push/pop (caller guarantees not full / not empty);
//   din/dout; full, empty, count; ent_valid/ent_addr expose the live entries for hazard compares
module wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_req_t                  din,
    output wb_req_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         ent_valid,
    output logic [ADDRESS_WIDTH-1:0] ent_addr [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end
    assign dout  = mem_q[rd_q];
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    // An entry is live when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_valid[i] = {1'b0, PW'(PW'(i) - rd_q)} < cnt_q;
        assign ent_addr[i]  = mem_q[i].addr;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges the ALU (primary) and buffered long-latency (secondary) writebacks
//   onto the single register-file write port
//   clk, rst (async active-low); bus.slave carries the p_*/s_* request channels,
//   the q_addr/q_pending hazard query, fifo_count, and the registered we3/a3/wd3 port
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input logic            clk,
    input logic            rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic                     full, empty, push, pop, p_take, starved, hit;
    wb_req_t                  head;
    logic [FIFO_DEPTH-1:0]    ent_valid;
    logic [ADDRESS_WIDTH-1:0] ent_addr [FIFO_DEPTH];
    logic [SW-1:0]            starve_q, starve_d;
    logic                     we3_q, we3_d;
    logic [ADDRESS_WIDTH-1:0] a3_q, a3_d;
    logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       ('{addr: bus.s_addr, data: bus.s_data}),
        .dout      (head),
        .full      (full),
        .empty     (empty),
        .count     (bus.fifo_count),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );
    always_comb begin
        starved     = starve_q == SW'(STARVE_LIMIT);
        bus.p_ready = ~(starved & ~empty);
        bus.s_ready = ~full;
        push        = bus.s_valid & ~full & (bus.s_addr != '0);
        p_take      = bus.p_valid & bus.p_ready & (bus.p_addr != '0);
        // While starved the primary is held off, so p_take is already low and the head drains.
        pop         = ~empty & ~p_take;
        we3_d       = pop | p_take;
        a3_d        = pop ? head.addr : p_take ? bus.p_addr : a3_q;
        wd3_d       = pop ? head.data : p_take ? bus.p_data : wd3_q;
        starve_d    = (pop | empty) ? '0 : starved ? starve_q : starve_q + 1'b1;
        hit         = we3_q & (a3_q == bus.q_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) hit = hit | (ent_valid[i] & (ent_addr[i] == bus.q_addr));
        bus.q_pending = (bus.q_addr != '0) & hit;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
            we3_q    <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
        end else begin
            starve_q <= starve_d;
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
        end
    end
    assign bus.we3 = we3_q;
    assign bus.a3  = a3_q;
    assign bus.wd3 = wd3_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed checks with a write scoreboard for rf_wb_arbiter
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    wb_req_t exp_q [$];
    always #5 clk = ~clk;
    rf_wb_arbiter_if #(.FIFO_DEPTH(4)) bus ();
    rf_wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.p_valid = 1'b0;
        bus.s_valid = 1'b0;
    endtask
    task automatic drive_p(input logic [4:0] a, input logic [31:0] d);
        bus.p_valid = 1'b1;
        bus.p_addr  = a;
        bus.p_data  = d;
    endtask
    task automatic drive_s(input logic [4:0] a, input logic [31:0] d);
        bus.s_valid = 1'b1;
        bus.s_addr  = a;
        bus.s_data  = d;
    endtask
    // Every committed write must match the next expected write, in order.
    always @(negedge clk) begin
        if (rst && bus.we3 === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_we3", bus.we3, 0);
            else chk("write", {bus.a3, bus.wd3}, exp_q.pop_front());
        end
    end
    initial begin
        bus.p_valid = 0; bus.p_addr = 0; bus.p_data = 0;
        bus.s_valid = 0; bus.s_addr = 0; bus.s_data = 0;
        bus.q_addr  = 0;
        tick();
        tick();
        chk("rst_we3", bus.we3, 0);
        chk("rst_a3", bus.a3, 0);
        chk("rst_wd3", bus.wd3, 0);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_p_ready", bus.p_ready, 1);
        rst = 1'b1;
        tick();
        // primary only
        drive_p(5, 32'hDEADBEEF);
        exp_q.push_back('{addr: 5, data: 32'hDEADBEEF});
        tick();
        idle();
        chk("p_we3", bus.we3, 1);
        chk("p_a3", bus.a3, 5);
        chk("p_wd3", bus.wd3, 32'hDEADBEEF);
        tick();
        chk("p_we3_off", bus.we3, 0);
        // x0 filter on both channels
        drive_p(0, 32'h123);
        #1 chk("x0_p_ready", bus.p_ready, 1);
        tick();
        idle();
        drive_s(0, 32'h456);
        #1 chk("x0_s_ready", bus.s_ready, 1);
        tick();
        idle();
        chk("x0_we3_a", bus.we3, 0);
        chk("x0_count_a", bus.fifo_count, 0);
        tick();
        chk("x0_we3_b", bus.we3, 0);
        chk("x0_count_b", bus.fifo_count, 0);
        // collision: primary first, buffered secondary next
        drive_p(3, 32'h11);
        drive_s(7, 32'h22);
        exp_q.push_back('{addr: 3, data: 32'h11});
        exp_q.push_back('{addr: 7, data: 32'h22});
        tick();
        idle();
        chk("col_a3_1", bus.a3, 3);
        chk("col_wd3_1", bus.wd3, 32'h11);
        chk("col_count_1", bus.fifo_count, 1);
        tick();
        chk("col_a3_2", bus.a3, 7);
        chk("col_wd3_2", bus.wd3, 32'h22);
        chk("col_count_2", bus.fifo_count, 0);
        tick();
        // full and starvation
        for (int k = 0; k < 5; k++) exp_q.push_back('{addr: 5'(20 + k), data: 32'hA0 + k});
        exp_q.push_back('{addr: 10, data: 32'hB0});
        exp_q.push_back('{addr: 25, data: 32'hA5});
        for (int k = 1; k < 4; k++) exp_q.push_back('{addr: 5'(10 + k), data: 32'hB0 + k});
        for (int k = 0; k < 4; k++) begin
            drive_p(5'(20 + k), 32'hA0 + k);
            drive_s(5'(10 + k), 32'hB0 + k);
            #1 chk("st_s_ready_pre", bus.s_ready, 1);
            tick();
        end
        drive_p(24, 32'hA4);
        drive_s(14, 32'hB4);
        #1 chk("st_full", bus.s_ready, 0);
        chk("st_p_ready_c4", bus.p_ready, 1);
        chk("st_count4", bus.fifo_count, 4);
        tick();
        drive_p(25, 32'hA5);
        #1 chk("st_forced", bus.p_ready, 0);
        chk("st_full_pop", bus.s_ready, 0);
        tick();
        bus.s_valid = 1'b0;
        #1 chk("st_p_ready_c6", bus.p_ready, 1);
        chk("st_a3_10", bus.a3, 10);
        chk("st_count_refused", bus.fifo_count, 3);
        tick();
        idle();
        #1 chk("st_p_ready_c7", bus.p_ready, 1);
        repeat (4) tick();
        chk("st_drained", bus.fifo_count, 0);
        // hazard query
        drive_s(9, 32'h99);
        bus.q_addr = 9;
        exp_q.push_back('{addr: 9, data: 32'h99});
        #1 chk("hz_before", bus.q_pending, 0);
        tick();
        idle();
        #1 chk("hz_buffered", bus.q_pending, 1);
        bus.q_addr = 0;
        #1 chk("hz_x0", bus.q_pending, 0);
        bus.q_addr = 9;
        tick();
        chk("hz_on_port", bus.q_pending, 1);
        chk("hz_we3", bus.we3, 1);
        chk("hz_a3", bus.a3, 9);
        tick();
        chk("hz_after", bus.q_pending, 0);
        bus.q_addr = 0;
        // reset mid-traffic with three entries queued and a write on the port
        exp_q.push_back('{addr: 4, data: 32'h44});
        exp_q.push_back('{addr: 5, data: 32'h45});
        for (int k = 0; k < 3; k++) begin
            drive_p(5'(4 + k), 32'h44 + k);
            drive_s(5'(1 + k), 32'h1 + k);
            tick();
        end
        chk("mid_count", bus.fifo_count, 3);
        idle();
        rst = 1'b0;
        #1 chk("mid_we3", bus.we3, 0);
        chk("mid_a3", bus.a3, 0);
        chk("mid_wd3", bus.wd3, 0);
        chk("mid_count_clr", bus.fifo_count, 0);
        chk("mid_s_ready", bus.s_ready, 1);
        tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("post_count", bus.fifo_count, 0);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
